trigger_generator: RTL and testbench

Periodic pulse-train source for the camera/strobe trigger chain. It produces a burst of N pulses, or a continuous stream, with programmable period and pulse width. Its `trig` output drives the `s` input of the downstream delay/hold stage, which rising-edge-detects each pulse. Configuration is shadowed and applied with an `applyConfig` strobe, so the two stages can be reprogrammed together.

---
 rtl/trigger_generator_if.sv | 26 ++
 rtl/trigger_generator.sv | 85 ++++++++
 tb/tb_trigger_generator.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/trigger_generator_if.sv
// Control and configuration bundle between the trigger sequencer and its host.
interface trigger_generator_if #(
  parameter int NBITS = 16,
  parameter int PBITS = 8,
  parameter int CBITS = 8
);
  logic             start;
  logic             stop;
  logic [NBITS-1:0] configPeriod;
  logic [PBITS-1:0] configPulse;
  logic [CBITS-1:0] configBurst;
  logic             applyConfig;
  logic             trig;
  logic             running;
  logic [CBITS-1:0] pulseCount;

  modport master (
    output start, stop, configPeriod, configPulse, configBurst, applyConfig,
    input  trig, running, pulseCount
  );

  modport slave (
    input  start, stop, configPeriod, configPulse, configBurst, applyConfig,
    output trig, running, pulseCount
  );
endinterface

// File: rtl/trigger_generator.sv
// Periodic trigger pulse-train source: bursts of N pulses or a continuous
// stream, with shadowed period / pulse-width / burst-length configuration.
module trigger_generator #(
  parameter int NBITS = 16,
  parameter int PBITS = 8,
  parameter int CBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  trigger_generator_if.slave bus
);
  // state | meaning
  // IDLE  | no pulse train; pulseCount holds the last value
  // RUN   | phase counts 0..periodMax; trig high while phase <= pulseMax
  typedef enum logic {IDLE, RUN} state_t;

  localparam int W = (NBITS > PBITS) ? NBITS : PBITS;

  state_t           state, state_n;
  logic [NBITS-1:0] phase, phase_n;
  logic [CBITS-1:0] count, count_n;
  logic [NBITS-1:0] period_max;
  logic [PBITS-1:0] pulse_max;
  logic [CBITS-1:0] burst_max;
  logic             trig_q, running_q, trig_n;

  always_comb begin
    state_n = state;
    phase_n = phase;
    count_n = count;
    if (bus.applyConfig) begin
      state_n = IDLE;
      phase_n = '0;
    end else if (bus.stop) begin
      if (state == RUN) begin
        state_n = IDLE;
        phase_n = '0;
      end
    end else if (state == IDLE) begin
      if (bus.start) begin
        state_n = RUN;
        phase_n = '0;
        count_n = CBITS'(1);
      end
    end else if (phase != period_max) begin
      phase_n = phase + NBITS'(1);
    end else if (burst_max == '0 || count != burst_max) begin
      phase_n = '0;
      count_n = count + CBITS'(1);
    end else begin
      // last pulse of the burst done; count keeps its final value
      state_n = IDLE;
      phase_n = '0;
    end
    trig_n = (state_n == RUN) && (W'(phase_n) <= W'(pulse_max));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= '0;
      count      <= '0;
      period_max <= '0;
      pulse_max  <= '0;
      burst_max  <= '0;
      trig_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      if (bus.applyConfig) begin
        period_max <= bus.configPeriod;
        pulse_max  <= bus.configPulse;
        burst_max  <= bus.configBurst;
      end
      state     <= state_n;
      phase     <= phase_n;
      count     <= count_n;
      trig_q    <= trig_n;
      running_q <= (state_n == RUN);
    end
  end

  assign bus.trig       = trig_q;
  assign bus.running    = running_q;
  assign bus.pulseCount = count;
endmodule

// File: tb/tb_trigger_generator.sv
// Scoreboard bench for trigger_generator: a cycles-since-start model predicts
// trig/running/pulseCount for every edge; predictions are queued and compared.
module tb_trigger_generator;
  logic clk;
  logic reset;
  trigger_generator_if #(.NBITS(16), .PBITS(8), .CBITS(8)) bus ();

  trigger_generator #(.NBITS(16), .PBITS(8), .CBITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       trig;
    logic       running;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;
  int   hi_cycles;

  // reference model state
  bit   m_run;
  int   m_t, m_per, m_pul, m_bur, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_t = 0; m_per = 0; m_pul = 0; m_bur = 0; m_cnt = 0;
  endtask

  // predict the outputs that the coming edge must produce
  task automatic model_edge();
    exp_t e;
    if (bus.applyConfig) begin
      m_per = int'(bus.configPeriod);
      m_pul = int'(bus.configPulse);
      m_bur = int'(bus.configBurst);
      m_run = 0;
    end else if (bus.stop) begin
      m_run = 0;
    end else if (bus.start && !m_run) begin
      m_run = 1; m_t = 0; m_cnt = 1;
    end else if (m_run) begin
      m_t++;
      if (m_bur != 0 && m_t >= m_bur * (m_per + 1)) begin
        m_run = 0;
        m_cnt = m_bur;
      end else begin
        m_cnt = (m_t / (m_per + 1) + 1) % 256;
      end
    end
    e.running = m_run;
    e.trig    = m_run && ((m_t % (m_per + 1)) <= m_pul);
    e.cnt     = 8'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_trig"}, 32'(bus.trig), 32'(e.trig));
      check({tag, "_running"}, 32'(bus.running), 32'(e.running));
      check({tag, "_count"}, 32'(bus.pulseCount), 32'(e.cnt));
    end
    if (bus.running) hi_cycles++;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic apply_cfg(input string tag, input int per, input int pul, input int bur);
    bus.configPeriod = 16'(per);
    bus.configPulse  = 8'(pul);
    bus.configBurst  = 8'(bur);
    bus.applyConfig  = 1'b1;
    tick(tag);
    bus.applyConfig  = 1'b0;
  endtask

  task automatic pulse_start(input string tag);
    bus.start = 1'b1;
    tick(tag);
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop(input string tag);
    bus.stop = 1'b1;
    tick(tag);
    bus.stop = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; hi_cycles = 0;
    bus.start = 0; bus.stop = 0; bus.applyConfig = 0;
    bus.configPeriod = 0; bus.configPulse = 0; bus.configBurst = 0;
    model_reset();
    reset = 1'b1;
    #2;
    check("rst_trig", 32'(bus.trig), 0);
    check("rst_running", 32'(bus.running), 0);
    check("rst_count", 32'(bus.pulseCount), 0);
    #1 reset = 1'b0;

    // 1: burst of 3, period 10, 3-cycle pulses
    apply_cfg("t1_cfg", 9, 2, 3);
    hi_cycles = 0;
    pulse_start("t1_start");
    check("t1_start_latency", 32'(bus.trig & bus.running), 1);
    run("t1", 34);
    check("t1_running_cycles", 32'(hi_cycles), 30);
    check("t1_final_count", 32'(bus.pulseCount), 3);

    // 2: continuous 1-cycle pulses every 5 cycles, count wrap, then stop
    apply_cfg("t2_cfg", 4, 0, 0);
    pulse_start("t2_start");
    run("t2", 256 * 5 - 1);
    check("t2_wrap_count", 32'(bus.pulseCount), 0);
    run("t2b", 7);
    pulse_stop("t2_stop");
    check("t2_stop_trig", 32'(bus.trig), 0);
    check("t2_stop_running", 32'(bus.running), 0);
    run("t2_idle", 3);

    // 3: pulse wider than period -> trig high for whole 8-cycle burst
    apply_cfg("t3_cfg", 3, 7, 2);
    hi_cycles = 0;
    pulse_start("t3_start");
    run("t3", 10);
    check("t3_running_cycles", 32'(hi_cycles), 8);
    check("t3_final_count", 32'(bus.pulseCount), 2);

    // 4: reconfigure mid-run, then restart with period 2
    apply_cfg("t4_cfg0", 4, 1, 0);
    pulse_start("t4_start0");
    run("t4_run0", 6);
    apply_cfg("t4_cfg1", 1, 0, 0);
    check("t4_abort_running", 32'(bus.running), 0);
    run("t4_idle", 2);
    pulse_start("t4_start1");
    run("t4_run1", 9);
    pulse_stop("t4_stop");

    // 5: start during RUN is ignored; start+applyConfig stays IDLE
    apply_cfg("t5_cfg", 5, 1, 4);
    pulse_start("t5_start");
    for (int i = 0; i < 20; i++) begin
      bus.start = (i % 3 == 0);
      tick("t5_restart");
    end
    bus.start = 0;
    run("t5_tail", 6);
    bus.start = 1'b1;
    apply_cfg("t5_start_apply", 2, 0, 0);
    bus.start = 1'b0;
    check("t5_same_edge_idle", 32'(bus.running), 0);
    run("t5_idle", 3);

    // 6: asynchronous reset mid-pulse clears outputs and shadows
    apply_cfg("t6_cfg", 9, 4, 0);
    pulse_start("t6_start");
    run("t6_run", 2);
    #2 reset = 1'b1;
    #1;
    check("t6_async_trig", 32'(bus.trig), 0);
    check("t6_async_running", 32'(bus.running), 0);
    check("t6_async_count", 32'(bus.pulseCount), 0);
    #1 reset = 1'b0;
    model_reset();
    run("t6_idle", 2);
    pulse_start("t6_start2");
    run("t6_const", 6);
    check("t6_const_trig", 32'(bus.trig), 1);
    pulse_stop("t6_stop");

    check("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
